mc_ctrl_v2: RTL and testbench

Second-generation multicycle MIPS control FSM. It decodes the 6-bit opcode (and funct, for JR) into per-state datapath strobes, as the current controller does. It adds three things: a memory ready/wait handshake with a parametrised timeout, precise handling of illegal opcodes through an exception state, and register-indirect jumps. It sits between the instruction register and the multicycle datapath, and its outputs are decoded purely from `state`, except where this spec states `mem_ready` gating.

---
 rtl/mc_ctrl_v2.sv | 236 +++++++++++++++++++++++
 tb/tb_mc_ctrl_v2.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_v2.sv
// mc_ctrl_v2 -- multicycle MIPS control FSM, second generation.
//
// Decodes OP (and funct for JR) into per-state datapath strobes. Adds a
// memory ready/wait handshake with a timeout that traps into BERR, an EXC
// state for illegal opcodes, and register-indirect jumps (JR).
//
// Parameters:
//   WAIT_W     width of the memory wait counter
//   TIMEOUT    max consecutive mem_ready=0 cycles in IF/MEM_RD/MEM_ST
//   SUPPORT_JR 1: R-type funct 001000 is JR, 0: treated as normal R-type
//
// Ports:
//   clk, rst (sync, active-low)      clock and reset
//   OP, funct                        IR[31:26], IR[5:0]
//   mem_ready                        memory completes this cycle
//   RegDst..RaWrite, ALUOp, ALUSrcB  datapath strobes
//   PCSource                         0 ALU, 1 ALUOut, 2 jump, 3 reg A, 4 exc vector
//   state                            current state
//   exc                              one-cycle pulse in EXC
//   bus_err                          high while in BERR (sticky until reset)
module mc_ctrl_v2 #(
  parameter int WAIT_W     = 4,
  parameter int TIMEOUT    = 15,
  parameter bit SUPPORT_JR = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] OP,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic       ALUctrInst,
  output logic       IorD,
  output logic       IRWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       PCWriteCond,
  output logic       PCWrite,
  output logic       PCCondSrc,
  output logic       RaWrite,
  output logic [1:0] ALUOp,
  output logic [1:0] ALUSrcB,
  output logic [2:0] PCSource,
  output logic [4:0] state,
  output logic       exc,
  output logic       bus_err
);

  typedef enum logic [4:0] {
    S_IF     = 5'd0,
    S_ID     = 5'd1,
    S_EX_LS  = 5'd2,
    S_MEM_RD = 5'd3,
    S_WB_LS  = 5'd4,
    S_MEM_ST = 5'd5,
    S_EX_R   = 5'd6,
    S_WB_R   = 5'd7,
    S_BEQ    = 5'd8,
    S_J      = 5'd9,
    S_BNE    = 5'd10,
    S_ADDI   = 5'd11,
    S_IMM_WB = 5'd12,
    S_JAL    = 5'd13,
    S_LOGI   = 5'd14,
    S_RST    = 5'd15,
    S_EXC    = 5'd16,
    S_BERR   = 5'd17,
    S_JR     = 5'd18
  } stateT;

  typedef struct packed {
    logic       regDst;
    logic       regWrite;
    logic       aluSrcA;
    logic       aluCtrInst;
    logic       iorD;
    logic       irWriteRdy;   // IRWrite, still to be qualified by mem_ready
    logic       memRead;
    logic       memWrite;
    logic       memtoReg;
    logic       pcWriteCond;
    logic       pcWrite;      // unconditional PC write
    logic       pcWriteRdy;   // PC write qualified by mem_ready
    logic       pcCondSrc;
    logic       raWrite;
    logic [1:0] aluOp;
    logic [1:0] aluSrcB;
    logic [2:0] pcSource;
    logic       exc;
    logic       busErr;
  } ctlT;

  localparam logic [WAIT_W-1:0] TIMEOUT_C = WAIT_W'(TIMEOUT);

  stateT             stateQ, nextState;
  logic [WAIT_W-1:0] waitCnt, nextCnt;
  logic              memWait;
  ctlT               ctlQ;

  function automatic ctlT decode(stateT s);
    ctlT c;
    c = '0;
    case (s)
      S_IF: begin
        c.memRead    = 1'b1;
        c.aluSrcB    = 2'b01;
        c.irWriteRdy = 1'b1;
        c.pcWriteRdy = 1'b1;
      end
      S_ID:     c.aluSrcB = 2'b11;
      S_EX_LS:  begin c.aluSrcA = 1'b1; c.aluSrcB = 2'b10; end
      S_MEM_RD: begin c.iorD = 1'b1; c.memRead = 1'b1; end
      S_MEM_ST: begin c.iorD = 1'b1; c.memWrite = 1'b1; end
      S_WB_LS:  begin c.regWrite = 1'b1; c.memtoReg = 1'b1; end
      S_EX_R:   begin c.aluSrcA = 1'b1; c.aluOp = 2'b10; end
      S_WB_R:   begin c.regDst = 1'b1; c.regWrite = 1'b1; end
      S_BEQ: begin
        c.aluSrcA     = 1'b1;
        c.aluOp       = 2'b01;
        c.pcWriteCond = 1'b1;
        c.pcCondSrc   = 1'b1;
        c.pcSource    = 3'd1;
      end
      S_BNE: begin
        c.aluSrcA     = 1'b1;
        c.aluOp       = 2'b01;
        c.pcWriteCond = 1'b1;
        c.pcSource    = 3'd1;
      end
      S_ADDI:   begin c.aluSrcA = 1'b1; c.aluSrcB = 2'b10; end
      S_LOGI:   begin c.aluCtrInst = 1'b1; c.aluOp = 2'b11; end
      S_IMM_WB: c.regWrite = 1'b1;
      S_JAL:    begin c.regWrite = 1'b1; c.raWrite = 1'b1; end
      S_J:      begin c.pcWrite = 1'b1; c.pcSource = 3'd2; end
      S_JR:     begin c.pcWrite = 1'b1; c.pcSource = 3'd3; end
      S_EXC:    begin c.pcWrite = 1'b1; c.pcSource = 3'd4; c.exc = 1'b1; end
      S_BERR:   c.busErr = 1'b1;
      default:  ;
    endcase
    return c;
  endfunction

  always_comb begin
    nextState = S_IF;
    memWait   = 1'b0;
    case (stateQ)
      S_RST: nextState = S_IF;
      S_IF: begin
        memWait = 1'b1;
        if (mem_ready)                nextState = S_ID;
        else if (waitCnt == TIMEOUT_C) nextState = S_BERR;
        else                          nextState = S_IF;
      end
      S_ID: begin
        case (OP)
          6'b000000: nextState = (SUPPORT_JR && funct == 6'b001000) ? S_JR : S_EX_R;
          6'b000010: nextState = S_J;
          6'b000011: nextState = S_JAL;
          6'b000100: nextState = S_BEQ;
          6'b000101: nextState = S_BNE;
          6'b001000: nextState = S_ADDI;
          6'b001100, 6'b001101, 6'b001110: nextState = S_LOGI;
          6'b100011, 6'b101011: nextState = S_EX_LS;
          default:   nextState = S_EXC;
        endcase
      end
      S_EX_LS: begin
        if (OP == 6'b100011)      nextState = S_MEM_RD;
        else if (OP == 6'b101011) nextState = S_MEM_ST;
        else                      nextState = S_IF;
      end
      S_MEM_RD: begin
        memWait = 1'b1;
        if (mem_ready)                nextState = S_WB_LS;
        else if (waitCnt == TIMEOUT_C) nextState = S_BERR;
        else                          nextState = S_MEM_RD;
      end
      S_MEM_ST: begin
        memWait = 1'b1;
        if (mem_ready)                nextState = S_IF;
        else if (waitCnt == TIMEOUT_C) nextState = S_BERR;
        else                          nextState = S_MEM_ST;
      end
      S_EX_R:          nextState = S_WB_R;
      S_ADDI, S_LOGI:  nextState = S_IMM_WB;
      S_JAL:           nextState = S_J;
      S_BERR:          nextState = S_BERR;
      default:         nextState = S_IF;
    endcase

    if (nextState != stateQ)
      nextCnt = '0;
    else if (memWait && !mem_ready && waitCnt != TIMEOUT_C)
      nextCnt = waitCnt + 1'b1;
    else
      nextCnt = waitCnt;
  end

  // Strobes are registered by decoding the state being entered, so they
  // line up with stateQ exactly as a decode of the current state would.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stateQ  <= S_RST;
      waitCnt <= '0;
      ctlQ    <= decode(S_RST);
    end else begin
      stateQ  <= nextState;
      waitCnt <= nextCnt;
      ctlQ    <= decode(nextState);
    end
  end

  assign RegDst      = ctlQ.regDst;
  assign RegWrite    = ctlQ.regWrite;
  assign ALUSrcA     = ctlQ.aluSrcA;
  assign ALUctrInst  = ctlQ.aluCtrInst;
  assign IorD        = ctlQ.iorD;
  assign IRWrite     = ctlQ.irWriteRdy & mem_ready;
  assign MemRead     = ctlQ.memRead;
  assign MemWrite    = ctlQ.memWrite;
  assign MemtoReg    = ctlQ.memtoReg;
  assign PCWriteCond = ctlQ.pcWriteCond;
  assign PCWrite     = ctlQ.pcWrite | (ctlQ.pcWriteRdy & mem_ready);
  assign PCCondSrc   = ctlQ.pcCondSrc;
  assign RaWrite     = ctlQ.raWrite;
  assign ALUOp       = ctlQ.aluOp;
  assign ALUSrcB     = ctlQ.aluSrcB;
  assign PCSource    = ctlQ.pcSource;
  assign exc         = ctlQ.exc;
  assign bus_err     = ctlQ.busErr;
  assign state       = stateQ;

endmodule

// File: tb/tb_mc_ctrl_v2.sv
// Testbench for mc_ctrl_v2. Two instances share inputs: A uses defaults
// (TIMEOUT=15, JR on), B uses WAIT_W=2, TIMEOUT=3, JR off.
module tb_mc_ctrl_v2;

  typedef struct packed {
    logic       regDst;
    logic       regWrite;
    logic       aluSrcA;
    logic       aluCtrInst;
    logic       iorD;
    logic       irWrite;
    logic       memRead;
    logic       memWrite;
    logic       memtoReg;
    logic       pcWriteCond;
    logic       pcWrite;
    logic       pcCondSrc;
    logic       raWrite;
    logic [1:0] aluOp;
    logic [1:0] aluSrcB;
    logic [2:0] pcSource;
    logic       exc;
    logic       busErr;
  } outsT;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] OP = '0;
  logic [5:0] funct = '0;
  logic       mem_ready = 1'b0;

  logic       RegDstA, RegWriteA, ALUSrcAA, ALUctrInstA, IorDA, IRWriteA, MemReadA;
  logic       MemWriteA, MemtoRegA, PCWriteCondA, PCWriteA, PCCondSrcA, RaWriteA;
  logic [1:0] ALUOpA, ALUSrcBA;
  logic [2:0] PCSourceA;
  logic [4:0] stateA;
  logic       excA, bus_errA;

  logic       RegDstB, RegWriteB, ALUSrcAB, ALUctrInstB, IorDB, IRWriteB, MemReadB;
  logic       MemWriteB, MemtoRegB, PCWriteCondB, PCWriteB, PCCondSrcB, RaWriteB;
  logic [1:0] ALUOpB, ALUSrcBB;
  logic [2:0] PCSourceB;
  logic [4:0] stateB;
  logic       excB, bus_errB;

  always #5 clk = ~clk;

  mc_ctrl_v2 dutA (
    .clk(clk), .rst(rst), .OP(OP), .funct(funct), .mem_ready(mem_ready),
    .RegDst(RegDstA), .RegWrite(RegWriteA), .ALUSrcA(ALUSrcAA), .ALUctrInst(ALUctrInstA),
    .IorD(IorDA), .IRWrite(IRWriteA), .MemRead(MemReadA), .MemWrite(MemWriteA),
    .MemtoReg(MemtoRegA), .PCWriteCond(PCWriteCondA), .PCWrite(PCWriteA),
    .PCCondSrc(PCCondSrcA), .RaWrite(RaWriteA), .ALUOp(ALUOpA), .ALUSrcB(ALUSrcBA),
    .PCSource(PCSourceA), .state(stateA), .exc(excA), .bus_err(bus_errA)
  );

  mc_ctrl_v2 #(.WAIT_W(2), .TIMEOUT(3), .SUPPORT_JR(1'b0)) dutB (
    .clk(clk), .rst(rst), .OP(OP), .funct(funct), .mem_ready(mem_ready),
    .RegDst(RegDstB), .RegWrite(RegWriteB), .ALUSrcA(ALUSrcAB), .ALUctrInst(ALUctrInstB),
    .IorD(IorDB), .IRWrite(IRWriteB), .MemRead(MemReadB), .MemWrite(MemWriteB),
    .MemtoReg(MemtoRegB), .PCWriteCond(PCWriteCondB), .PCWrite(PCWriteB),
    .PCCondSrc(PCCondSrcB), .RaWrite(RaWriteB), .ALUOp(ALUOpB), .ALUSrcB(ALUSrcBB),
    .PCSource(PCSourceB), .state(stateB), .exc(excB), .bus_err(bus_errB)
  );

  outsT obsA, obsB;
  assign obsA = {RegDstA, RegWriteA, ALUSrcAA, ALUctrInstA, IorDA, IRWriteA, MemReadA,
                 MemWriteA, MemtoRegA, PCWriteCondA, PCWriteA, PCCondSrcA, RaWriteA,
                 ALUOpA, ALUSrcBA, PCSourceA, excA, bus_errA};
  assign obsB = {RegDstB, RegWriteB, ALUSrcAB, ALUctrInstB, IorDB, IRWriteB, MemReadB,
                 MemWriteB, MemtoRegB, PCWriteCondB, PCWriteB, PCCondSrcB, RaWriteB,
                 ALUOpB, ALUSrcBB, PCSourceB, excB, bus_errB};

  int checks = 0;
  int fails  = 0;

  // Reference model: state number, wait count and parameters per instance
  int mState[2];
  int mCnt[2];
  bit mValid = 1'b0;
  bit mJr[2] = '{1'b1, 1'b0};
  int mTo[2] = '{15, 3};

  // Strobe table per state number, as listed for the controller.
  function automatic outsT expOuts(int s, bit rdy);
    outsT o;
    o = '0;
    case (s)
      0:  begin o.memRead = 1; o.aluSrcB = 2'b01; o.irWrite = rdy; o.pcWrite = rdy; end
      1:  o.aluSrcB = 2'b11;
      2:  begin o.aluSrcA = 1; o.aluSrcB = 2'b10; end
      3:  begin o.iorD = 1; o.memRead = 1; end
      4:  begin o.regWrite = 1; o.memtoReg = 1; end
      5:  begin o.iorD = 1; o.memWrite = 1; end
      6:  begin o.aluSrcA = 1; o.aluOp = 2'b10; end
      7:  begin o.regDst = 1; o.regWrite = 1; end
      8:  begin o.aluSrcA = 1; o.aluOp = 2'b01; o.pcWriteCond = 1; o.pcCondSrc = 1; o.pcSource = 3'd1; end
      9:  begin o.pcWrite = 1; o.pcSource = 3'd2; end
      10: begin o.aluSrcA = 1; o.aluOp = 2'b01; o.pcWriteCond = 1; o.pcSource = 3'd1; end
      11: begin o.aluSrcA = 1; o.aluSrcB = 2'b10; end
      12: o.regWrite = 1;
      13: begin o.regWrite = 1; o.raWrite = 1; end
      14: begin o.aluCtrInst = 1; o.aluOp = 2'b11; end
      16: begin o.pcWrite = 1; o.pcSource = 3'd4; o.exc = 1; end
      17: o.busErr = 1;
      18: begin o.pcWrite = 1; o.pcSource = 3'd3; end
      default: ;
    endcase
    return o;
  endfunction

  function automatic int opTarget(logic [5:0] op, logic [5:0] fn, bit jr);
    case (op)
      6'd0:  return (jr && fn == 6'd8) ? 18 : 6;
      6'd2:  return 9;
      6'd3:  return 13;
      6'd4:  return 8;
      6'd5:  return 10;
      6'd8:  return 11;
      6'd12, 6'd13, 6'd14: return 14;
      6'd35, 6'd43: return 2;
      default: return 16;
    endcase
  endfunction

  function automatic int nextOf(int s, int cnt, logic [5:0] op, logic [5:0] fn, bit rdy, bit jr, int to);
    bit waits;
    waits = (s == 0 || s == 3 || s == 5);
    if (waits && !rdy) return (cnt == to) ? 17 : s;
    case (s)
      0:  return 1;
      1:  return opTarget(op, fn, jr);
      2:  return (op == 6'd35) ? 3 : ((op == 6'd43) ? 5 : 0);
      3:  return 4;
      6:  return 7;
      11, 14: return 12;
      13: return 9;
      17: return 17;
      default: return 0;
    endcase
  endfunction

  // One clock cycle: drive inputs at the falling edge, check, then advance.
  task automatic tick(input bit r, input logic [5:0] o, input logic [5:0] f,
                      input bit rd, input int wantA, input int wantB);
    int ns;
    @(negedge clk);
    rst = r; OP = o; funct = f; mem_ready = rd;
    #1;
    if (mValid) begin
      checks++;
      assert (stateA === 5'(mState[0])) else begin
        fails++; $error("FAIL stateA observed=%0d expected=%0d", stateA, mState[0]);
      end
      checks++;
      assert (obsA === expOuts(mState[0], rd)) else begin
        fails++; $error("FAIL outsA st=%0d observed=%h expected=%h", mState[0], obsA, expOuts(mState[0], rd));
      end
      checks++;
      assert (stateB === 5'(mState[1])) else begin
        fails++; $error("FAIL stateB observed=%0d expected=%0d", stateB, mState[1]);
      end
      checks++;
      assert (obsB === expOuts(mState[1], rd)) else begin
        fails++; $error("FAIL outsB st=%0d observed=%h expected=%h", mState[1], obsB, expOuts(mState[1], rd));
      end
    end
    if (wantA >= 0) begin
      checks++;
      assert (stateA === 5'(wantA)) else begin
        fails++; $error("FAIL seqA observed=%0d expected=%0d", stateA, wantA);
      end
    end
    if (wantB >= 0) begin
      checks++;
      assert (stateB === 5'(wantB)) else begin
        fails++; $error("FAIL seqB observed=%0d expected=%0d", stateB, wantB);
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (!r) begin
        mState[i] = 15;
        mCnt[i]   = 0;
      end else begin
        ns = nextOf(mState[i], mCnt[i], o, f, rd, mJr[i], mTo[i]);
        if (ns != mState[i])                                  mCnt[i] = 0;
        else if ((ns == 0 || ns == 3 || ns == 5) && !rd && mCnt[i] < mTo[i]) mCnt[i] = mCnt[i] + 1;
        mState[i] = ns;
      end
    end
    if (!r) mValid = 1'b1;
    @(posedge clk);
  endtask

  localparam logic [5:0] RTYPE = 6'd0, LW = 6'd35, SW = 6'd43, BAD = 6'd63;
  localparam logic [5:0] F_ADD = 6'b100000, F_JR = 6'b001000;

  initial begin
    logic [5:0] ops [12];
    logic [5:0] rop, rfn;
    ops = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd8, 6'd12, 6'd13, 6'd14, 6'd35, 6'd43, 6'd63};

    // Reset held for three cycles, then an R-type with zero wait states
    tick(0, RTYPE, F_ADD, 1, -1, -1);
    tick(0, RTYPE, F_ADD, 1, 15, 15);
    tick(0, RTYPE, F_ADD, 1, 15, 15);
    tick(1, RTYPE, F_ADD, 1, 15, 15);
    tick(1, RTYPE, F_ADD, 1, 0, 0);
    tick(1, RTYPE, F_ADD, 1, 1, 1);
    tick(1, RTYPE, F_ADD, 1, 6, 6);
    tick(1, RTYPE, F_ADD, 1, 7, 7);

    // Load with three wait cycles in MEM_RD
    tick(1, LW, 0, 1, 0, 0);
    tick(1, LW, 0, 1, 1, 1);
    tick(1, LW, 0, 1, 2, 2);
    tick(1, LW, 0, 0, 3, 3);
    tick(1, LW, 0, 0, 3, 3);
    tick(1, LW, 0, 0, 3, 3);
    tick(1, LW, 0, 1, 3, 3);
    tick(1, LW, 0, 1, 4, 4);

    // Store
    tick(1, SW, 0, 1, 0, 0);
    tick(1, SW, 0, 1, 1, 1);
    tick(1, SW, 0, 1, 2, 2);
    tick(1, SW, 0, 1, 5, 5);

    // Illegal opcode
    tick(1, BAD, 0, 1, 0, 0);
    tick(1, BAD, 0, 1, 1, 1);
    tick(1, BAD, 0, 1, 16, 16);

    // JR: A takes it, B treats it as R-type
    tick(1, RTYPE, F_JR, 1, 0, 0);
    tick(1, RTYPE, F_JR, 1, 1, 1);
    tick(1, RTYPE, F_JR, 1, 18, 6);
    tick(1, RTYPE, F_JR, 1, 0, 7);
    tick(0, RTYPE, F_JR, 1, -1, -1);

    // mem_ready on the timeout cycle wins (B, TIMEOUT=3)
    tick(1, RTYPE, F_ADD, 0, 15, 15);
    tick(1, RTYPE, F_ADD, 0, 0, 0);
    tick(1, RTYPE, F_ADD, 0, 0, 0);
    tick(1, RTYPE, F_ADD, 0, 0, 0);
    tick(1, RTYPE, F_ADD, 1, 0, 0);
    tick(1, RTYPE, F_ADD, 1, 1, 1);
    tick(0, RTYPE, F_ADD, 1, -1, -1);

    // Timeout in IF: A after 16 cycles, B after 4; BERR is sticky
    tick(1, RTYPE, F_ADD, 0, 15, 15);
    for (int k = 1; k <= 16; k++) tick(1, RTYPE, F_ADD, 0, 0, (k <= 4) ? 0 : 17);
    tick(1, RTYPE, F_ADD, 0, 17, 17);
    tick(1, RTYPE, F_ADD, 1, 17, 17);
    tick(1, RTYPE, F_ADD, 1, 17, 17);
    checks++;
    assert (bus_errA === 1'b1) else begin
      fails++; $error("FAIL busErrSticky observed=%b expected=1", bus_errA);
    end
    tick(0, RTYPE, F_ADD, 1, 17, 17);
    tick(1, RTYPE, F_ADD, 1, 15, 15);

    // Randomised traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rop = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 11)];
      rfn = ($urandom_range(0, 1) == 0) ? F_JR : 6'($urandom);
      tick(($urandom_range(0, 59) != 0), rop, rfn, ($urandom_range(0, 9) < 7), -1, -1);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
